// File: rtl/chiptune_pkg.sv
// Shared constants and types for the chiptune frame sequencer.
// Holds the NTSC (default) and PAL step tick counts, the sequencer
// state encoding and the decoded step-event record.
package chiptune_pkg;

    // NTSC frame-counter step points, in CPU-rate ticks
    localparam int NTSC_STEP1 = 7457;
    localparam int NTSC_STEP2 = 14913;
    localparam int NTSC_STEP3 = 22371;
    localparam int NTSC_STEP4 = 29829;
    localparam int NTSC_STEP5 = 37281;

    // PAL alternative
    localparam int PAL_STEP1  = 8313;
    localparam int PAL_STEP2  = 16627;
    localparam int PAL_STEP3  = 24939;
    localparam int PAL_STEP4  = 33253;
    localparam int PAL_STEP5  = 41565;

    localparam int SEQ_CNT_W    = 16;
    localparam int SEQ_WR_DELAY = 3;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } seq_state_e;

    // One decoded step boundary: which strobes fire, whether the frame
    // IRQ is requested, whether the counter wraps, and the step index.
    typedef struct packed {
        logic       hit;
        logic       quarter;
        logic       half;
        logic       irq;
        logic       wrap;
        logic [2:0] step;
    } step_evt_t;

endpackage

// File: rtl/apu_frame_sequencer_if.sv
// Bus between the register decoder / channel generators and the frame
// sequencer.
//   ce               CPU-rate tick, one clk wide
//   cfg_we           config write strobe
//   cfg_mode         0 = 4-step, 1 = 5-step
//   cfg_irq_inhibit  1 = suppress and clear frame IRQ
//   irq_ack          status-read strobe, clears frame IRQ
//   quarter_frame    one-clk strobe
//   half_frame       one-clk strobe
//   frame_irq        level IRQ flag
//   step             last step reached, 0..5
interface apu_frame_sequencer_if;
    logic       ce;
    logic       cfg_we;
    logic       cfg_mode;
    logic       cfg_irq_inhibit;
    logic       irq_ack;
    logic       quarter_frame;
    logic       half_frame;
    logic       frame_irq;
    logic [2:0] step;

    modport master (
        output ce, cfg_we, cfg_mode, cfg_irq_inhibit, irq_ack,
        input  quarter_frame, half_frame, frame_irq, step
    );

    modport slave (
        input  ce, cfg_we, cfg_mode, cfg_irq_inhibit, irq_ack,
        output quarter_frame, half_frame, frame_irq, step
    );
endinterface

// File: rtl/frame_step_decode.sv
// Combinational step decoder: maps a (freshly incremented) tick count and
// the sequencer mode onto the step event for that tick.
//   cnt   tick count after increment
//   mode  0 = 4-step, 1 = 5-step
//   evt   decoded event (hit/quarter/half/irq/wrap/step)
module frame_step_decode
    import chiptune_pkg::*;
#(
    parameter int CNT_W = SEQ_CNT_W,
    parameter int STEP1 = NTSC_STEP1,
    parameter int STEP2 = NTSC_STEP2,
    parameter int STEP3 = NTSC_STEP3,
    parameter int STEP4 = NTSC_STEP4,
    parameter int STEP5 = NTSC_STEP5
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             mode,
    output step_evt_t        evt
);

    always_comb begin
        evt = '0;
        if (cnt == CNT_W'(STEP1)) begin
            evt.hit     = 1'b1;
            evt.quarter = 1'b1;
            evt.step    = 3'd1;
        end else if (cnt == CNT_W'(STEP2)) begin
            evt.hit     = 1'b1;
            evt.quarter = 1'b1;
            evt.half    = 1'b1;
            evt.step    = 3'd2;
        end else if (cnt == CNT_W'(STEP3)) begin
            evt.hit     = 1'b1;
            evt.quarter = 1'b1;
            evt.step    = 3'd3;
        end else if (cnt == CNT_W'(STEP4)) begin
            // In 5-step mode step 4 is a silent step: index only.
            evt.hit  = 1'b1;
            evt.step = 3'd4;
            if (!mode) begin
                evt.quarter = 1'b1;
                evt.half    = 1'b1;
                evt.irq     = 1'b1;
                evt.wrap    = 1'b1;
            end
        end else if (mode && (cnt == CNT_W'(STEP5))) begin
            evt.hit     = 1'b1;
            evt.quarter = 1'b1;
            evt.half    = 1'b1;
            evt.wrap    = 1'b1;
            evt.step    = 3'd5;
        end
    end

endmodule

// File: rtl/apu_frame_sequencer.sv
// Frame-rate scheduler (NES APU frame counter style). Counts ce ticks,
// emits quarter/half-frame strobes at the step points, raises the frame
// IRQ in 4-step mode, and restarts the count WR_DELAY ticks after a
// configuration write.
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   apu_frame_sequencer_if.slave (ce, cfg_*, irq_ack in; strobes,
//         frame_irq, step out)
//
// state | meaning
// RUN   | normal counting
// PEND  | config write accepted, counter restart pending (dcnt ticks left)
module apu_frame_sequencer
    import chiptune_pkg::*;
#(
    parameter int CNT_W    = SEQ_CNT_W,
    parameter int STEP1    = NTSC_STEP1,
    parameter int STEP2    = NTSC_STEP2,
    parameter int STEP3    = NTSC_STEP3,
    parameter int STEP4    = NTSC_STEP4,
    parameter int STEP5    = NTSC_STEP5,
    parameter int WR_DELAY = SEQ_WR_DELAY
) (
    input  logic                  clk,
    input  logic                  rst,
    apu_frame_sequencer_if.slave  bus
);

    localparam int DCNT_W = $clog2(WR_DELAY + 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d, dly;
    logic              mode_q, mode_d, mode_eff;
    logic              inhibit_q, inhibit_d;
    logic              qf_q, qf_d;
    logic              hf_q, hf_d;
    logic              irq_q, irq_d;
    logic [2:0]        step_q, step_d;
    logic              pend, restart, irq_set;
    step_evt_t         evt;

    // A write applies its mode to the tick it arrives with.
    assign mode_eff = bus.cfg_we ? bus.cfg_mode : mode_q;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    frame_step_decode #(
        .CNT_W (CNT_W),
        .STEP1 (STEP1),
        .STEP2 (STEP2),
        .STEP3 (STEP3),
        .STEP4 (STEP4),
        .STEP5 (STEP5)
    ) u_decode (
        .cnt  (cnt_inc),
        .mode (mode_eff),
        .evt  (evt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        inhibit_d = inhibit_q;
        qf_d      = 1'b0;
        hf_d      = 1'b0;
        irq_d     = irq_q;
        step_d    = step_q;
        dly       = dcnt_q;
        pend      = (state_q == PEND);
        restart   = 1'b0;
        irq_set   = 1'b0;

        // A write (first or repeated) reloads the restart delay.
        if (bus.cfg_we) begin
            mode_d    = bus.cfg_mode;
            inhibit_d = bus.cfg_irq_inhibit;
            pend      = 1'b1;
            dly       = DCNT_W'(WR_DELAY);
        end

        if (bus.ce) begin
            if (pend) begin
                dly     = dly - DCNT_W'(1);
                restart = (dly == '0);
            end
            if (restart) begin
                // The restart tick replaces any step event; 5-step mode
                // clocks the units once right away.
                cnt_d  = '0;
                step_d = 3'd0;
                qf_d   = mode_d;
                hf_d   = mode_d;
            end else begin
                cnt_d = evt.wrap ? '0 : cnt_inc;
                if (evt.hit) begin
                    qf_d    = evt.quarter;
                    hf_d    = evt.half;
                    step_d  = evt.step;
                    irq_set = evt.irq & ~inhibit_d;
                end
            end
        end

        state_d = (pend && !restart) ? PEND : RUN;
        dcnt_d  = restart ? '0 : dly;

        // Setting the flag wins over a same-cycle acknowledge.
        if (bus.irq_ack || inhibit_d) begin
            irq_d = 1'b0;
        end
        if (irq_set) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            dcnt_q    <= '0;
            mode_q    <= 1'b0;
            inhibit_q <= 1'b0;
            qf_q      <= 1'b0;
            hf_q      <= 1'b0;
            irq_q     <= 1'b0;
            step_q    <= 3'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dcnt_q    <= dcnt_d;
            mode_q    <= mode_d;
            inhibit_q <= inhibit_d;
            qf_q      <= qf_d;
            hf_q      <= hf_d;
            irq_q     <= irq_d;
            step_q    <= step_d;
        end
    end

    assign bus.quarter_frame = qf_q;
    assign bus.half_frame    = hf_q;
    assign bus.frame_irq     = irq_q;
    assign bus.step          = step_q;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Bench for apu_frame_sequencer: a scaled-down instance checked against a
// behavioural model, plus a default-parameter instance checked for the
// real NTSC step positions.
module tb_apu_frame_sequencer;

    localparam int SP1 = 7;
    localparam int SP2 = 15;
    localparam int SP3 = 22;
    localparam int SP4 = 30;
    localparam int SP5 = 37;
    localparam int WD  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_d = 1'b0;

    always #5 clk = ~clk;

    apu_frame_sequencer_if sif ();
    apu_frame_sequencer_if dif ();

    apu_frame_sequencer #(
        .CNT_W (8), .STEP1 (SP1), .STEP2 (SP2), .STEP3 (SP3),
        .STEP4 (SP4), .STEP5 (SP5), .WR_DELAY (WD)
    ) dut (
        .clk (clk), .rst (rst), .bus (sif.slave)
    );

    apu_frame_sequencer dut_dflt (
        .clk (clk), .rst (rst_d), .bus (dif.slave)
    );

    int n_pass = 0;
    int n_tot  = 0;

    // ---------------- reference model ----------------
    int pts[1:5];
    int m_pos, m_mode, m_inh, m_dly, m_irq, m_step;
    bit e_qf, e_hf;

    task automatic model_reset();
        m_pos = 0; m_mode = 0; m_inh = 0; m_dly = 0; m_irq = 0; m_step = 0;
        e_qf = 0; e_hf = 0;
    endtask

    // m_dly > 0 means a restart is pending; that many ticks remain.
    task automatic model_step(input bit ce, input bit we, input bit md,
                              input bit inh, input bit ack);
        bit restart = 0;
        bit set = 0;
        int k;
        e_qf = 0; e_hf = 0;
        if (we) begin
            m_mode = md; m_inh = inh; m_dly = WD;
            if (inh) m_irq = 0;
        end
        if (ce) begin
            if (m_dly > 0) begin
                m_dly = m_dly - 1;
                if (m_dly == 0) begin
                    restart = 1; m_pos = 0; m_step = 0;
                    e_qf = (m_mode == 1); e_hf = (m_mode == 1);
                end
            end
            if (!restart) begin
                m_pos = (m_pos + 1) % 256;
                k = 0;
                for (int i = 1; i <= 5; i++) if (m_pos == pts[i]) k = i;
                if (k == 5 && m_mode == 0) k = 0;
                if (k != 0) begin
                    m_step = k;
                    e_qf = !(k == 4 && m_mode == 1);
                    e_hf = (k == 2) || (k == 5) || (k == 4 && m_mode == 0);
                    if (k == 4 && m_mode == 0) begin
                        m_pos = 0;
                        set = (m_inh == 0);
                    end
                    if (k == 5) m_pos = 0;
                end
            end
        end
        if (ack) m_irq = 0;
        if (set) m_irq = 1;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [7:0] obs();
        return {2'b00, sif.quarter_frame, sif.half_frame, sif.frame_irq, sif.step};
    endfunction

    task automatic cyc(input bit ce, input bit we, input bit md, input bit inh, input bit ack);
        @(negedge clk);
        sif.ce = ce; sif.cfg_we = we; sif.cfg_mode = md;
        sif.cfg_irq_inhibit = inh; sif.irq_ack = ack;
        model_step(ce, we, md, inh, ack);
        @(posedge clk);
        #1;
        chk("model", obs(), {2'b00, e_qf, e_hf, m_irq[0], 3'(m_step)});
        sif.ce = 0; sif.cfg_we = 0; sif.irq_ack = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        sif.ce = 0; sif.cfg_we = 0; sif.cfg_mode = 0; sif.cfg_irq_inhibit = 0; sif.irq_ack = 0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset", obs(), 8'h00);
        @(negedge clk);
        rst = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit ce, we, md, inh, ack;
        bit eq, eh, ei;
        int es;
    } vec_t;

    vec_t vt[11];

    function automatic vec_t mk(bit ce, bit we, bit md, bit inh, bit ack,
                                bit eq, bit eh, bit ei, int es);
        vec_t v;
        v.ce = ce; v.we = we; v.md = md; v.inh = inh; v.ack = ack;
        v.eq = eq; v.eh = eh; v.ei = ei; v.es = es;
        return v;
    endfunction

    initial begin
        int irq_rise;
        bit saw;
        int qq[$];
        int hq[$];
        int exp_q[5];

        pts[1] = SP1; pts[2] = SP2; pts[3] = SP3; pts[4] = SP4; pts[5] = SP5;
        sif.ce = 0; sif.cfg_we = 0; sif.cfg_mode = 0; sif.cfg_irq_inhibit = 0; sif.irq_ack = 0;
        dif.ce = 0; dif.cfg_we = 0; dif.cfg_mode = 0; dif.cfg_irq_inhibit = 0; dif.irq_ack = 0;
        rst_d = 1;
        model_reset();

        //             ce we md ih ak   q  h  i  step
        vt[0]  = mk(0, 1, 1, 0, 0,   0, 0, 0, 0);   // write 5-step, no tick
        vt[1]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0);   // delay 2 left
        vt[2]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0);   // delay 1 left
        vt[3]  = mk(0, 0, 0, 0, 1,   0, 0, 0, 0);   // idle, stray ack
        vt[4]  = mk(1, 0, 0, 0, 0,   1, 1, 0, 0);   // restart: mode-1 pulse
        vt[5]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0);
        vt[6]  = mk(1, 1, 0, 0, 0,   0, 0, 0, 0);   // write with tick: delay 2 left
        vt[7]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0);
        vt[8]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0);   // restart, 4-step: silent
        vt[9]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0);
        vt[10] = mk(0, 1, 0, 1, 0,   0, 0, 0, 0);

        do_reset();
        for (int i = 0; i < 11; i++) begin
            cyc(vt[i].ce, vt[i].we, vt[i].md, vt[i].inh, vt[i].ack);
            chk($sformatf("vec%0d", i), obs(),
                {2'b00, vt[i].eq, vt[i].eh, vt[i].ei, 3'(vt[i].es)});
        end

        // 4-step run from reset
        do_reset();
        for (int t = 1; t <= 40; t++) begin
            cyc(1, 0, 0, 0, 0);
            chk($sformatf("mode0_t%0d", t), {5'b0, sif.quarter_frame, sif.half_frame, sif.frame_irq},
                {5'b0, 1'(t == 7 || t == 15 || t == 22 || t == 30 || t == 37),
                 1'(t == 15 || t == 30), 1'(t >= 30)});
        end

        // switch to 5-step (ack clears the pending IRQ)
        cyc(0, 1, 1, 0, 1);
        ticks(2);
        cyc(1, 0, 0, 0, 0);
        chk("m1_restart", {6'b0, sif.quarter_frame, sif.half_frame}, 8'h03);
        for (int t = 1; t <= 40; t++) begin
            cyc(1, 0, 0, 0, 0);
            chk($sformatf("mode1_t%0d", t), {5'b0, sif.quarter_frame, sif.half_frame, sif.frame_irq},
                {5'b0, 1'(t == 7 || t == 15 || t == 22 || t == 37),
                 1'(t == 15 || t == 37), 1'b0});
        end

        // IRQ set vs ack in the same cycle
        cyc(0, 1, 0, 0, 0);
        ticks(3);
        ticks(30);
        chk("irq_first", {7'b0, sif.frame_irq}, 8'h01);
        ticks(29);
        cyc(1, 0, 0, 0, 1);
        chk("irq_race", {7'b0, sif.frame_irq}, 8'h01);
        cyc(0, 0, 0, 0, 1);
        chk("irq_ack", {7'b0, sif.frame_irq}, 8'h00);

        // inhibit clears and holds off the IRQ
        ticks(30);
        chk("irq_set", {7'b0, sif.frame_irq}, 8'h01);
        cyc(0, 1, 0, 1, 0);
        chk("inh_clear", {7'b0, sif.frame_irq}, 8'h00);
        ticks(3);
        saw = 0;
        for (int i = 0; i < 62; i++) begin
            cyc(1, 0, 0, 0, 0);
            if (sif.frame_irq) saw = 1;
        end
        chk("inh_hold", {7'b0, saw}, 8'h00);
        cyc(0, 1, 0, 0, 0);
        ticks(3);

        // second write during PEND: one restart, 3 ticks after it
        ticks(4);
        cyc(0, 1, 0, 0, 0);
        ticks(2);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("pend_step", {4'b0, sif.quarter_frame, sif.step}, 8'h09);
        cyc(1, 0, 0, 0, 0);
        chk("pend_hold", {5'b0, sif.step}, 8'h01);
        cyc(1, 0, 0, 0, 0);
        chk("restart2", {4'b0, sif.quarter_frame, sif.step}, 8'h00);
        for (int t = 1; t <= 7; t++) begin
            cyc(1, 0, 0, 0, 0);
            chk($sformatf("post_restart_t%0d", t), {7'b0, sif.quarter_frame}, {7'b0, 1'(t == 7)});
        end

        // reset while a 5-step restart is pending
        cyc(0, 1, 1, 0, 0);
        ticks(3);
        ticks(25);
        cyc(0, 1, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        do_reset();
        for (int t = 1; t <= 8; t++) begin
            cyc(1, 0, 0, 0, 0);
            chk($sformatf("rst_pend_t%0d", t), {6'b0, sif.quarter_frame, sif.half_frame},
                {6'b0, 1'(t == 7), 1'b0});
        end

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
                1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
                $urandom_range(0, 19) == 0);
        end

        // default NTSC instance, ce every clk
        @(posedge clk);
        #1;
        chk("dflt_reset", {2'b00, dif.quarter_frame, dif.half_frame, dif.frame_irq, dif.step}, 8'h00);
        @(negedge clk);
        rst_d = 0;
        dif.ce = 1;
        irq_rise = 0;
        for (int t = 1; t <= 37290; t++) begin
            @(posedge clk);
            #1;
            if (dif.quarter_frame) qq.push_back(t);
            if (dif.half_frame) hq.push_back(t);
            if (dif.frame_irq && irq_rise == 0) irq_rise = t;
        end
        @(negedge clk);
        dif.ce = 0;
        exp_q = '{7457, 14913, 22371, 29829, 37286};
        chk("dflt_qcount", 8'(qq.size()), 8'd5);
        for (int i = 0; i < 5; i++) begin
            n_tot++;
            if (i < qq.size() && qq[i] == exp_q[i]) n_pass++;
            else $display("FAIL dflt_quarter%0d: got %0d expected %0d", i,
                          (i < qq.size()) ? qq[i] : -1, exp_q[i]);
        end
        chk("dflt_hcount", 8'(hq.size()), 8'd2);
        n_tot++;
        if (hq.size() == 2 && hq[0] == 14913 && hq[1] == 29829) n_pass++;
        else $display("FAIL dflt_half: got %p expected 14913,29829", hq);
        n_tot++;
        if (irq_rise == 29829) n_pass++;
        else $display("FAIL dflt_irq_rise: got %0d expected 29829", irq_rise);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/apu_frame_sequencer.md
Name: apu_frame_sequencer

Overview:
- Frame-rate scheduler for the chiptune audio engine, derived from the NES APU frame counter.
- Counts CPU-rate clock-enable ticks and emits single-cycle quarter-frame and half-frame strobes to the envelope, linear-counter, length and sweep units.
- Raises the frame IRQ flag.
- Configured by the serial-write decoder via $4017-style writes (mode, IRQ inhibit). Sits between the register decoder and the channel generators inside chiptune.

Parameters:
- CNT_W, 16, width of the tick counter.
- STEP1, 7457, tick count of step 1.
- STEP2, 14913, tick count of step 2.
- STEP3, 22371, tick count of step 3.
- STEP4, 29829, tick count of step 4 (4-step wrap point).
- STEP5, 37281, tick count of step 5 (5-step wrap point).
- WR_DELAY, 3, ce ticks between a config write and the counter restart.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- ce  input  1  CPU-rate tick, one clk wide (CLKRATE/2 rate)
- cfg_we  input  1  config write strobe
- cfg_mode  input  1  0 = 4-step, 1 = 5-step (data bit 7)
- cfg_irq_inhibit  input  1  1 = suppress and clear frame IRQ (data bit 6)
- irq_ack  input  1  status-read strobe; clears frame IRQ
- quarter_frame  output  1  one-clk strobe
- half_frame  output  1  one-clk strobe
- frame_irq  output  1  level IRQ flag
- step  output  3  index of the last step reached, 0..5

Behaviour:
- All outputs registered. Reset values:
  - quarter_frame = 0, half_frame = 0, frame_irq = 0, step = 0.
  - Counter = 0, mode = 0, inhibit = 0, state = RUN.
- Counter: increments by 1 on each clk with ce = 1. It never increments without ce.
- Step events: compare the incremented value. The strobe is asserted in the clk cycle after the ce cycle and lasts 1 clk.
  - STEP1: quarter. step = 1.
  - STEP2: quarter + half. step = 2.
  - STEP3: quarter. step = 3.
  - STEP4, mode 0: quarter + half. Set frame_irq if inhibit = 0. Counter wraps to 0. step = 4.
  - STEP4, mode 1: no strobe. step = 4. Counting continues.
  - STEP5, mode 1: quarter + half. Counter wraps to 0. step = 5. No IRQ.
  - Mode 0 never reaches STEP5.
- Wrap timing: the counter value after a wrap tick is 0. The next ce makes it 1. Period is STEP4 ticks in mode 0 and STEP5 ticks in mode 1.
- FSM states:
  - RUN: normal counting.
  - PEND: write accepted, restart pending. Holds a delay counter dcnt of width clog2(WR_DELAY+1).
- Writes:
  - On cfg_we, mode and inhibit update in the same cycle.
  - If inhibit = 1, frame_irq clears the next cycle.
  - The FSM goes to PEND with dcnt = WR_DELAY.
- In PEND:
  - The counter keeps counting and step events fire normally under the new mode.
  - Each ce decrements dcnt.
  - On the ce where dcnt reaches 0: counter <= 0, step <= 0, FSM -> RUN. That ce produces no step event.
  - If mode = 1, quarter_frame and half_frame pulse once in the following cycle.
- Second cfg_we while in PEND: reload dcnt = WR_DELAY and apply the new mode/inhibit. Only one restart occurs.
- Simultaneous events:
  - cfg_we and ce in the same cycle: the write is taken first; that ce counts as the first delay tick.
  - IRQ set and irq_ack in the same cycle: set wins.
  - IRQ set and inhibit = 1: no set.
- irq_ack clears frame_irq the next cycle.
- rst has priority over all inputs and returns to the reset state from any state, including PEND.
- Counter width: CNT_W must hold STEP5. Comparisons are unsigned equality.

Decomposition:
- Shared package chiptune_pkg holds:
  - The default step constants STEP1..STEP5 (NTSC).
  - A PAL alternative set.
  - State encoding: RUN = 1'b0, PEND = 1'b1.
- One natural sub-module: frame_step_decode. It is combinational: counter value + mode -> quarter/half/irq/wrap/step.
- The top holds the counter, the FSM, the delay counter and the output registers.

Test Plan:
- Run with ce every clk after reset (mode 0) -> quarter at ticks 7457, 14913, 22371, 29829; half at 14913 and 29829; frame_irq rises after 29829; next quarter at 29829 + 7457.
- cfg_we with mode = 1 → after WR_DELAY = 3 ce ticks the counter goes to 0 and quarter + half pulse immediately. Then quarter fires at 7457/14913/22371, none at 29829, and quarter + half fire at 37281, with no frame_irq ever.
- frame_irq set, then irq_ack in the same cycle as the next IRQ set (force with a STEP4 = 8 build) -> frame_irq stays 1. A later irq_ack alone -> 0.
- frame_irq = 1, then cfg_we with inhibit = 1 -> 0 the next cycle. Run 2 periods -> stays 0.
- cfg_we, then second cfg_we 2 ce later -> a single restart 3 ce after the second write. A step boundary crossed during PEND still strobes.
- Assert rst while in PEND with count 20000 -> all outputs 0, counter 0, next quarter exactly 7457 ce later, no delayed mode-1 pulse.
